axis_sample_delay: RTL
======================

Name: axis_sample_delay

Overview:
- AXI4-Stream sample-count delay line for the signal phase alignment path.
- Feeds the x16 left-shift gain stage, which sits directly downstream.
- Delays the raw ECG branch by exactly DELAY accepted samples. This matches the group delay of the parallel filtered branch, so the two branches stay sample-aligned.
- One output word per accepted input word; the first DELAY outputs after reset or clear are zero.

Parameters:
- WIDTH, 32, sample width in bits (signed two's complement, passed through unmodified).
- DELAY, 16, delay in samples; legal range 1..1024; need not be a power of two.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; restarts the priming sequence.
- s_axis_tvalid  input  1  upstream sample valid.
- s_axis_tdata  input  WIDTH  upstream signed sample.
- s_axis_tready  output  1  block can accept a sample.
- m_axis_tvalid  output  1  delayed sample valid.
- m_axis_tdata  output  WIDTH  delayed signed sample.
- m_axis_tready  input  1  downstream (gain stage) ready.
- primed  output  1  high once DELAY samples have been accepted since reset or clear.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: m_axis_tvalid=0, m_axis_tdata=0, primed=0, write pointer=0, fill count=0. Buffer contents are not reset; they are masked by primed.
- s_axis_tready = (!m_axis_tvalid || m_axis_tready) && !clr. This is combinational from registered state, so the block supports full throughput (one sample per clock).
- accept = s_axis_tvalid && s_axis_tready.
- Storage is a DELAY-entry circular buffer indexed by ptr (width clog2(DELAY), minimum 1 bit).
- On accept:
  - read-before-write at ptr: m_axis_tdata <= primed ? buf[ptr] : 0.
  - buf[ptr] <= s_axis_tdata.
  - ptr <= (ptr==DELAY-1) ? 0 : ptr+1.
  - m_axis_tvalid <= 1.
- Latency: input accepted at cycle n produces its output beat at cycle n+1. Sample k appears as output beat k+DELAY (beats counted from 0).
- Fill count and primed:
  - fill count saturates at DELAY.
  - primed is registered; it goes to 1 on the clock edge of the accept that brings the count to DELAY.
  - Accept DELAY (0-based), the first accept with primed=1, outputs sample 0.
- Output hold:
  - m_axis_tvalid=1 and m_axis_tready=0: m_axis_tdata is held stable and no input is accepted (AXIS compliant).
  - m_axis_tready=1 with no accept: m_axis_tvalid <= 0.
  - Accept and output handshake in the same cycle: the new beat replaces the old one and m_axis_tvalid stays 1.
- Wrap-around: ptr wraps from DELAY-1 to 0 with no bubble.
- clr=1 at a clock edge has priority over accept:
  - s_axis_tready=0, so no sample is taken.
  - ptr, fill count, primed and m_axis_tvalid are cleared, and m_axis_tdata is set to 0.
  - Any pending output beat is discarded. clr is used only during stream re-sync.
- Reset asserted mid-stream: all state is cleared immediately. After release, outputs are zero again for DELAY samples.
- DELAY=1: single-entry buffer. The first output is 0; after that, output k is input k-1.
- Arithmetic: none. Data is bit-exact and sign is preserved.

Decomposition:
- Shared package: axis_pkg_sample constants: DEFAULT_WIDTH=32, MAX_DELAY=1024, and a clog2 helper function for the pointer width.
- One sub-module is natural: sample_delay_ram.
  - Simple single-port DELAY x WIDTH RAM with synchronous read-before-write (read data from the same address the edge writes).
  - Maps to distributed or block RAM.
- The top level holds ptr, fill count, primed, the output valid register and the handshake logic.

Test Plan:
- Priming, WIDTH=32, DELAY=4, tvalid and tready held high, inputs 1,2,3,...,10:
  - outputs are 0,0,0,0,1,2,3,4,5,6.
  - primed rises on the edge of the 4th accept.
  - one output beat per cycle, latency 1.
- Backpressure: hold m_axis_tready=0 for 3 cycles with m_axis_tvalid=1 and data=5:
  - m_axis_tdata stays 5.
  - s_axis_tready=0.
  - no input is lost; the sequence resumes 6,7,... on release.
- Negative values and wrap, DELAY=3: inputs -1, -32768, 0x7FFFFFFF, -2, over 20 samples:
  - outputs are bit-exact copies delayed by 3 beats.
  - ptr wraps 2->0 with no bubbles.
- Sparse input: s_axis_tvalid toggles 1,0,0,1,... with DELAY=2:
  - the delay counts samples, not cycles.
  - m_axis_tvalid pulses once per accepted input.
- clr mid-stream after 10 samples, with clr and s_axis_tvalid high together:
  - that input is not accepted.
  - the pending output is dropped and primed=0.
  - the next DELAY outputs are 0, then samples taken after clr appear.
- Async reset asserted mid-beat: with m_axis_tvalid=1, pull rst_n low between clock edges:
  - m_axis_tvalid, m_axis_tdata and primed go to 0 immediately, without waiting for a clock edge.
  - after release, re-priming zeros are observed.

Source files
------------

// File: rtl/axis_sample_delay_pkg.sv
// Shared constants and pointer-width helper for the sample delay line.
package axis_pkg_sample;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MAX_DELAY     = 1024;

  // ceil(log2(n)), never less than 1 so a single-entry buffer still gets an index bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = 1; v < n; v = v << 1) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_sample_delay_ram.sv
// Single-port DEPTH x WIDTH RAM with synchronous read-before-write on one address.
module sample_delay_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/axis_sample_delay.sv
// AXI4-Stream delay line: each accepted sample re-emerges DELAY accepted samples later.
module axis_sample_delay
  import axis_pkg_sample::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DELAY = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_axis_tvalid,
  input  logic [WIDTH-1:0] s_axis_tdata,
  output logic             s_axis_tready,
  output logic             m_axis_tvalid,
  output logic [WIDTH-1:0] m_axis_tdata,
  input  logic             m_axis_tready,
  output logic             primed
);

  localparam int unsigned AW = clog2_min1(DELAY);
  localparam int unsigned FW = clog2_min1(DELAY + 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DELAY - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DELAY);
  localparam logic [FW-1:0] FILL_LAST = FW'(DELAY - 1);

  logic [AW-1:0]    ptr;
  logic [FW-1:0]    fill;
  logic             out_live;
  logic             accept;
  logic [WIDTH-1:0] ram_rdata;

  assign s_axis_tready = (!m_axis_tvalid || m_axis_tready) && !clr;
  assign accept        = s_axis_tvalid && s_axis_tready;

  sample_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (accept),
    .addr  (ptr),
    .wdata (s_axis_tdata),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; out_live masks it so reset/clr zero the
  // output immediately and unprimed reads never leak stale buffer contents.
  assign m_axis_tdata = out_live ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      fill          <= '0;
      primed        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      out_live      <= 1'b0;
    end else if (clr) begin
      ptr           <= '0;
      fill          <= '0;
      primed        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      out_live      <= 1'b0;
    end else if (accept) begin
      ptr           <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      m_axis_tvalid <= 1'b1;
      out_live      <= primed;
      if (fill != FILL_FULL) fill <= fill + 1'b1;
      if (fill == FILL_LAST) primed <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
